pmem_icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between one core's fetcher and one program-memory

---
 rtl/pmem_icache_pkg.sv | 36 +++
 rtl/icache_line_store.sv | 54 +++++
 rtl/pmem_icache.sv | 186 ++++++++++++++++++
 tb/tb_pmem_icache.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_icache_pkg.sv
// Shared types, default geometry and address-split helpers for the program-memory I-cache.
package pmem_icache_pkg;

   typedef logic [2:0] icache_state_e;

   localparam icache_state_e IDLE         = 3'd0;
   localparam icache_state_e LOOKUP       = 3'd1;
   localparam icache_state_e FILL_REQ     = 3'd2;
   localparam icache_state_e FILL_WAIT    = 3'd3;
   localparam icache_state_e FILL_RELEASE = 3'd4;
   localparam icache_state_e RESPOND      = 3'd5;

   localparam int unsigned DEF_ADDR_BITS      = 8;
   localparam int unsigned DEF_DATA_BITS      = 16;
   localparam int unsigned DEF_NUM_LINES      = 16;
   localparam int unsigned DEF_WORDS_PER_LINE = 2;

   function automatic int unsigned offset_bits(input int unsigned words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int unsigned index_bits(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_bits(input int unsigned addr_bits,
                                            input int unsigned num_lines,
                                            input int unsigned words_per_line);
      return addr_bits - $clog2(num_lines) - $clog2(words_per_line);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays for the direct-mapped I-cache: one async read port, one word write
// port, a line-valid set port and a flash clear of all valid bits.
module icache_line_store
   import pmem_icache_pkg::*;
#(
   parameter int unsigned DATA_BITS      = DEF_DATA_BITS,
   parameter int unsigned NUM_LINES      = DEF_NUM_LINES,
   parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   parameter int unsigned TAG_BITS       = 3
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [index_bits(NUM_LINES)-1:0]        rd_index_i,
   input  logic [offset_bits(WORDS_PER_LINE)-1:0]  rd_offset_i,
   output logic [TAG_BITS-1:0]                     rd_tag_o,
   output logic                                    rd_valid_o,
   output logic [DATA_BITS-1:0]                    rd_data_o,
   input  logic                                    wr_en_i,
   input  logic [index_bits(NUM_LINES)-1:0]        wr_index_i,
   input  logic [offset_bits(WORDS_PER_LINE)-1:0]  wr_offset_i,
   input  logic [DATA_BITS-1:0]                    wr_data_i,
   input  logic                                    set_valid_i,
   input  logic [index_bits(NUM_LINES)-1:0]        set_index_i,
   input  logic [TAG_BITS-1:0]                     set_tag_i,
   input  logic                                    clear_all_i
);

   logic [DATA_BITS-1:0] data_q [NUM_LINES][WORDS_PER_LINE];
   logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;

   // Payload arrays are deliberately left unreset; only the valid bits gate their use.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         data_q[wr_index_i][wr_offset_i] <= wr_data_i;
      end
      if (set_valid_i) begin
         tag_q[set_index_i] <= set_tag_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear_all_i) begin
         valid_q <= '0;
      end else if (set_valid_i) begin
         valid_q[set_index_i] <= 1'b1;
      end
   end

   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

endmodule

// File: rtl/pmem_icache.sv
// Direct-mapped read-only instruction cache between a core fetcher and one program-memory port;
// misses fill the whole line word 0 upward over a 4-phase valid/ready handshake.
module pmem_icache
   import pmem_icache_pkg::*;
#(
   parameter int unsigned ADDR_BITS      = DEF_ADDR_BITS,
   parameter int unsigned DATA_BITS      = DEF_DATA_BITS,
   parameter int unsigned NUM_LINES      = DEF_NUM_LINES,
   parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fetch_read_valid,
   input  logic [ADDR_BITS-1:0] fetch_read_address,
   output logic                 fetch_read_ready,
   output logic [DATA_BITS-1:0] fetch_read_data,
   input  logic                 flush,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic [15:0]          hit_count,
   output logic [15:0]          miss_count
);

   localparam int unsigned OFF_W = offset_bits(WORDS_PER_LINE);
   localparam int unsigned IDX_W = index_bits(NUM_LINES);
   localparam int unsigned TAG_W = tag_bits(ADDR_BITS, NUM_LINES, WORDS_PER_LINE);
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

   icache_state_e        state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [OFF_W-1:0]     ctr_q, ctr_d;
   logic                 flush_pending_q, flush_pending_d;
   logic                 ready_q, ready_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 mem_valid_q, mem_valid_d;
   logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]          hit_q, hit_d;
   logic [15:0]          miss_q, miss_d;

   logic [OFF_W-1:0]     addr_off;
   logic [IDX_W-1:0]     addr_idx;
   logic [TAG_W-1:0]     addr_tag;
   logic [TAG_W-1:0]     rd_tag;
   logic                 rd_valid;
   logic [DATA_BITS-1:0] rd_data;
   logic                 wr_en;
   logic                 set_valid;
   logic                 clear_all;

   assign addr_off = addr_q[OFF_W-1:0];
   assign addr_idx = addr_q[OFF_W +: IDX_W];
   assign addr_tag = addr_q[ADDR_BITS-1 -: TAG_W];

   icache_line_store #(
      .DATA_BITS      (DATA_BITS),
      .NUM_LINES      (NUM_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_BITS       (TAG_W)
   ) u_line_store (
      .clk         (clk),
      .reset       (reset),
      .rd_index_i  (addr_idx),
      .rd_offset_i (addr_off),
      .rd_tag_o    (rd_tag),
      .rd_valid_o  (rd_valid),
      .rd_data_o   (rd_data),
      .wr_en_i     (wr_en),
      .wr_index_i  (addr_idx),
      .wr_offset_i (ctr_q),
      .wr_data_i   (mem_read_data),
      .set_valid_i (set_valid),
      .set_index_i (addr_idx),
      .set_tag_i   (addr_tag),
      .clear_all_i (clear_all)
   );

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      ctr_d           = ctr_q;
      ready_d         = ready_q;
      data_d          = data_q;
      mem_valid_d     = mem_valid_q;
      mem_addr_d      = mem_addr_q;
      hit_d           = hit_q;
      miss_d          = miss_q;
      wr_en           = 1'b0;
      set_valid       = 1'b0;
      clear_all       = 1'b0;
      // A flush is only recorded here; invalidation waits for IDLE so a fill never tears.
      flush_pending_d = flush_pending_q | flush;

      case (state_q)
         IDLE: begin
            if (flush_pending_q) begin
               clear_all       = 1'b1;
               flush_pending_d = flush;
            end else if (fetch_read_valid) begin
               addr_d  = fetch_read_address;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (rd_valid && (rd_tag == addr_tag)) begin
               hit_d   = sat_inc16(hit_q);
               data_d  = rd_data;
               ready_d = 1'b1;
               state_d = RESPOND;
            end else begin
               miss_d  = sat_inc16(miss_q);
               ctr_d   = '0;
               state_d = FILL_REQ;
            end
         end
         FILL_REQ: begin
            mem_valid_d = 1'b1;
            mem_addr_d  = {addr_tag, addr_idx, ctr_q};
            state_d     = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (mem_read_ready) begin
               wr_en       = 1'b1;
               mem_valid_d = 1'b0;
               state_d     = FILL_RELEASE;
            end
         end
         FILL_RELEASE: begin
            // Waiting for ready to drop keeps valid from rising into a still-high ready.
            if (!mem_read_ready) begin
               if (ctr_q == LAST_WORD) begin
                  set_valid = 1'b1;
                  data_d    = rd_data;
                  ready_d   = 1'b1;
                  state_d   = RESPOND;
               end else begin
                  ctr_d   = ctr_q + OFF_W'(1);
                  state_d = FILL_REQ;
               end
            end
         end
         RESPOND: begin
            if (!fetch_read_valid) begin
               ready_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         ctr_q           <= '0;
         flush_pending_q <= 1'b0;
         ready_q         <= 1'b0;
         data_q          <= '0;
         mem_valid_q     <= 1'b0;
         mem_addr_q      <= '0;
         hit_q           <= '0;
         miss_q          <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         ctr_q           <= ctr_d;
         flush_pending_q <= flush_pending_d;
         ready_q         <= ready_d;
         data_q          <= data_d;
         mem_valid_q     <= mem_valid_d;
         mem_addr_q      <= mem_addr_d;
         hit_q           <= hit_d;
         miss_q          <= miss_d;
      end
   end

   assign fetch_read_ready = ready_q;
   assign fetch_read_data  = data_q;
   assign mem_read_valid   = mem_valid_q;
   assign mem_read_address = mem_addr_q;
   assign hit_count        = hit_q;
   assign miss_count       = miss_q;

endmodule

// File: tb/tb_pmem_icache.sv
// Directed bench for pmem_icache: behavioural program memory with fixed response latency.
module tb_pmem_icache;

   localparam int MEM_LAT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_read_valid = 1'b0;
   logic [7:0]  fetch_read_address = 8'h00;
   logic        fetch_read_ready;
   logic [15:0] fetch_read_data;
   logic        flush = 1'b0;
   logic        mem_read_valid;
   logic [7:0]  mem_read_address;
   logic        mem_read_ready = 1'b0;
   logic [15:0] mem_read_data = 16'h0000;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int          checks = 0;
   int          passes = 0;
   int          mem_reqs = 0;
   int          proto_err = 0;
   int          lat_cnt = 0;
   logic [7:0]  fill_q[$];
   logic [15:0] mem [256];
   logic        prev_mv = 1'b0;
   logic        prev_fv = 1'b0;
   logic [7:0]  prev_fa = 8'h00;
   bit          flush_sent = 1'b0;

   pmem_icache dut (
      .clk                (clk),
      .reset              (reset),
      .fetch_read_valid   (fetch_read_valid),
      .fetch_read_address (fetch_read_address),
      .fetch_read_ready   (fetch_read_ready),
      .fetch_read_data    (fetch_read_data),
      .flush              (flush),
      .mem_read_valid     (mem_read_valid),
      .mem_read_address   (mem_read_address),
      .mem_read_ready     (mem_read_ready),
      .mem_read_data      (mem_read_data),
      .hit_count          (hit_count),
      .miss_count         (miss_count)
   );

   always #5 clk = ~clk;

   // Program-memory model plus request/protocol monitor, all evaluated on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_read_valid && !prev_mv) begin
            fill_q.push_back(mem_read_address);
            mem_reqs++;
            if (mem_read_ready) proto_err++;
         end
         if (fetch_read_valid && prev_fv && (fetch_read_address != prev_fa)) proto_err++;
      end
      prev_mv = mem_read_valid;
      prev_fv = fetch_read_valid;
      prev_fa = fetch_read_address;
      if (reset) begin
         mem_read_ready = 1'b0;
         lat_cnt = 0;
      end else if (mem_read_valid) begin
         if (!mem_read_ready) begin
            lat_cnt++;
            if (lat_cnt >= MEM_LAT) begin
               mem_read_ready = 1'b1;
               mem_read_data  = mem[mem_read_address];
            end
         end
      end else begin
         mem_read_ready = 1'b0;
         lat_cnt = 0;
      end
   end

   // Raises a request and waits (bounded) for ready; optionally pulses flush during the fill.
   task automatic do_fetch(input logic [7:0] a, input bit inj_flush,
                           output logic [15:0] d, output int cyc, output bit ok);
      bit sent = 1'b0;
      fetch_read_address = a;
      fetch_read_valid = 1'b1;
      cyc = 0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cyc++;
         flush = 1'b0;
         if (inj_flush && mem_read_valid && !sent) begin
            flush = 1'b1;
            sent = 1'b1;
            flush_sent = 1'b1;
         end
         if (fetch_read_ready) begin
            ok = 1'b1;
            break;
         end
      end
      flush = 1'b0;
      d = fetch_read_data;
   endtask

   task automatic release_fetch();
      fetch_read_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++; if (fetch_read_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", fetch_read_ready); else passes++;
      checks++; if (fetch_read_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", fetch_read_data); else passes++;
      checks++; if (mem_read_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_read_valid); else passes++;
      checks++; if (mem_read_address !== 8'h0) $display("FAIL reset_mem_addr: got %h want 00", mem_read_address); else passes++;
      checks++; if (hit_count !== 16'h0) $display("FAIL reset_hits: got %0d want 0", hit_count); else passes++;
      checks++; if (miss_count !== 16'h0) $display("FAIL reset_misses: got %0d want 0", miss_count); else passes++;
   endtask

   task automatic test_cold_miss();
      logic [15:0] d; int cyc; bit ok;
      fill_q.delete();
      do_fetch(8'h05, 1'b0, d, cyc, ok);
      checks++; if (ok !== 1'b1) $display("FAIL cold_done: got %b want 1 (timeout)", ok); else passes++;
      checks++; if (d !== 16'hC3D4) $display("FAIL cold_data: got %h want c3d4", d); else passes++;
      checks++; if (miss_count !== 16'd1) $display("FAIL cold_misses: got %0d want 1", miss_count); else passes++;
      checks++; if (hit_count !== 16'd0) $display("FAIL cold_hits: got %0d want 0", hit_count); else passes++;
      checks++; if (fill_q.size() !== 2) $display("FAIL cold_fill_len: got %0d want 2", fill_q.size()); else passes++;
      checks++; if (fill_q[0] !== 8'h04) $display("FAIL cold_fill0: got %h want 04", fill_q[0]); else passes++;
      checks++; if (fill_q[1] !== 8'h05) $display("FAIL cold_fill1: got %h want 05", fill_q[1]); else passes++;
      release_fetch();
      checks++; if (fetch_read_ready !== 1'b0) $display("FAIL cold_ready_drop: got %b want 0", fetch_read_ready); else passes++;
   endtask

   task automatic test_hit();
      logic [15:0] d; int cyc; bit ok; int r0;
      r0 = mem_reqs;
      do_fetch(8'h04, 1'b0, d, cyc, ok);
      checks++; if (cyc !== 2) $display("FAIL hit_latency: got %0d want 2", cyc); else passes++;
      checks++; if (d !== 16'hA1B2) $display("FAIL hit_data: got %h want a1b2", d); else passes++;
      checks++; if (mem_reqs !== r0) $display("FAIL hit_no_mem: got %0d want %0d", mem_reqs, r0); else passes++;
      checks++; if (hit_count !== 16'd1) $display("FAIL hit_count: got %0d want 1", hit_count); else passes++;
      release_fetch();
   endtask

   task automatic test_conflict();
      logic [15:0] d; int cyc; bit ok;
      do_fetch(8'h05, 1'b0, d, cyc, ok);
      checks++; if (d !== 16'hC3D4) $display("FAIL conf_hit_data: got %h want c3d4", d); else passes++;
      checks++; if (hit_count !== 16'd2) $display("FAIL conf_hits: got %0d want 2", hit_count); else passes++;
      release_fetch();
      fill_q.delete();
      do_fetch(8'h25, 1'b0, d, cyc, ok);
      checks++; if (d !== 16'h25DA) $display("FAIL conf_new_data: got %h want 25da", d); else passes++;
      checks++; if (fill_q[0] !== 8'h24) $display("FAIL conf_fill0: got %h want 24", fill_q[0]); else passes++;
      release_fetch();
      do_fetch(8'h05, 1'b0, d, cyc, ok);
      checks++; if (d !== 16'hC3D4) $display("FAIL conf_refill_data: got %h want c3d4", d); else passes++;
      checks++; if (miss_count !== 16'd3) $display("FAIL conf_misses: got %0d want 3", miss_count); else passes++;
      release_fetch();
   endtask

   task automatic test_flush_mid_fill();
      logic [15:0] d; int cyc; bit ok; int r0;
      r0 = mem_reqs;
      do_fetch(8'h10, 1'b1, d, cyc, ok);
      checks++; if (flush_sent !== 1'b1) $display("FAIL flush_injected: got %b want 1", flush_sent); else passes++;
      checks++; if (d !== 16'h10EF) $display("FAIL flush_data: got %h want 10ef", d); else passes++;
      checks++; if (miss_count !== 16'd4) $display("FAIL flush_misses1: got %0d want 4", miss_count); else passes++;
      release_fetch();
      do_fetch(8'h10, 1'b0, d, cyc, ok);
      checks++; if (d !== 16'h10EF) $display("FAIL flush_refetch_data: got %h want 10ef", d); else passes++;
      checks++; if (miss_count !== 16'd5) $display("FAIL flush_misses2: got %0d want 5", miss_count); else passes++;
      checks++; if (mem_reqs !== r0 + 4) $display("FAIL flush_mem_reqs: got %0d want %0d", mem_reqs, r0 + 4); else passes++;
      release_fetch();
   endtask

   task automatic test_slow_consumer();
      logic [15:0] d; int cyc; bit ok; int r0;
      r0 = mem_reqs;
      do_fetch(8'h10, 1'b0, d, cyc, ok);
      checks++; if (cyc !== 2) $display("FAIL slow_latency: got %0d want 2", cyc); else passes++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++; if (fetch_read_ready !== 1'b1) $display("FAIL slow_ready_%0d: got %b want 1", i, fetch_read_ready); else passes++;
         checks++; if (fetch_read_data !== 16'h10EF) $display("FAIL slow_data_%0d: got %h want 10ef", i, fetch_read_data); else passes++;
      end
      checks++; if (mem_reqs !== r0) $display("FAIL slow_no_mem: got %0d want %0d", mem_reqs, r0); else passes++;
      checks++; if (hit_count !== 16'd3) $display("FAIL slow_hits: got %0d want 3", hit_count); else passes++;
      release_fetch();
   endtask

   task automatic test_reset_mid_fill();
      logic [15:0] d; int cyc; bit ok; bit seen = 1'b0;
      fetch_read_address = 8'h30;
      fetch_read_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mem_read_valid) begin
            seen = 1'b1;
            break;
         end
      end
      checks++; if (seen !== 1'b1) $display("FAIL rst_fill_started: got %b want 1", seen); else passes++;
      reset = 1'b1;
      fetch_read_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_read_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b want 0", mem_read_valid); else passes++;
      checks++; if (fetch_read_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", fetch_read_ready); else passes++;
      checks++; if (fetch_read_data !== 16'h0) $display("FAIL rst_data: got %h want 0000", fetch_read_data); else passes++;
      checks++; if (mem_read_address !== 8'h0) $display("FAIL rst_mem_addr: got %h want 00", mem_read_address); else passes++;
      checks++; if (hit_count !== 16'h0) $display("FAIL rst_hits: got %0d want 0", hit_count); else passes++;
      checks++; if (miss_count !== 16'h0) $display("FAIL rst_misses: got %0d want 0", miss_count); else passes++;
      reset = 1'b0;
      @(negedge clk);
      do_fetch(8'h10, 1'b0, d, cyc, ok);
      checks++; if (d !== 16'h10EF) $display("FAIL rst_refetch_data: got %h want 10ef", d); else passes++;
      checks++; if (miss_count !== 16'd1) $display("FAIL rst_refetch_miss: got %0d want 1", miss_count); else passes++;
      checks++; if (hit_count !== 16'd0) $display("FAIL rst_refetch_hits: got %0d want 0", hit_count); else passes++;
      release_fetch();
   endtask

   task automatic test_protocol();
      checks++; if (proto_err !== 0) $display("FAIL protocol: got %0d violations want 0", proto_err); else passes++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = {i[7:0], ~i[7:0]};
      end
      mem[8'h04] = 16'hA1B2;
      mem[8'h05] = 16'hC3D4;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_cold_miss();
      test_hit();
      test_conflict();
      test_flush_mid_fill();
      test_slow_consumer();
      test_reset_mid_fill();
      test_protocol();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
